// File: rtl/slot_occupancy.sv
// Bay sensor conditioning: 2-flop synchronizer plus per-bay debounce FSM,
// producing clean occupancy bits, arrival/departure strobes and a bay count.
module slot_occupancy #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] slot_sensor,
  output logic       car1_state,
  output logic       car2_state,
  output logic       car3_state,
  output logic [2:0] arrive_pulse,
  output logic [2:0] depart_pulse,
  output logic [1:0] occupied_count
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    ARRIVING  = 2'd1,
    OCCUPIED  = 2'd2,
    DEPARTING = 2'd3
  } bay_state_t;

  // The counter holds samples already seen, so the D-th agreeing sample lands on D-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0] sync1_reg;
  logic [2:0] sens_s_reg;
  logic [2:0] state_bits;
  logic [2:0] arrive_bits;
  logic [2:0] depart_bits;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg  <= '0;
      sens_s_reg <= '0;
    end else begin
      sync1_reg  <= slot_sensor;
      sens_s_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_bay
      bay_state_t       fsm_reg, fsm_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             bit_reg, bit_next;
      logic             arrive_reg, arrive_next;
      logic             depart_reg, depart_next;
      logic             sens;

      assign sens = sens_s_reg[gi];

      always_ff @(posedge clk) begin
        if (reset) begin
          fsm_reg    <= EMPTY;
          cnt_reg    <= '0;
          bit_reg    <= 1'b0;
          arrive_reg <= 1'b0;
          depart_reg <= 1'b0;
        end else begin
          fsm_reg    <= fsm_next;
          cnt_reg    <= cnt_next;
          bit_reg    <= bit_next;
          arrive_reg <= arrive_next;
          depart_reg <= depart_next;
        end
      end

      always_comb begin
        fsm_next    = fsm_reg;
        cnt_next    = cnt_reg;
        bit_next    = bit_reg;
        arrive_next = 1'b0;
        depart_next = 1'b0;
        case (fsm_reg)
          EMPTY: begin
            if (sens) begin
              fsm_next = ARRIVING;
              cnt_next = CNT_W'(1);
            end
          end
          ARRIVING: begin
            if (!sens) begin
              fsm_next = EMPTY;
              cnt_next = '0;
            end else if (cnt_reg == CNT_LAST) begin
              fsm_next    = OCCUPIED;
              cnt_next    = '0;
              bit_next    = 1'b1;
              arrive_next = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          OCCUPIED: begin
            if (!sens) begin
              fsm_next = DEPARTING;
              cnt_next = CNT_W'(1);
            end
          end
          DEPARTING: begin
            // A returning car cancels the departure without a strobe.
            if (sens) begin
              fsm_next = OCCUPIED;
              cnt_next = '0;
            end else if (cnt_reg == CNT_LAST) begin
              fsm_next    = EMPTY;
              cnt_next    = '0;
              bit_next    = 1'b0;
              depart_next = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          default: begin
            fsm_next = EMPTY;
            cnt_next = '0;
          end
        endcase
      end

      assign state_bits[gi]  = bit_reg;
      assign arrive_bits[gi] = arrive_reg;
      assign depart_bits[gi] = depart_reg;
    end
  endgenerate

  assign car1_state     = state_bits[0];
  assign car2_state     = state_bits[1];
  assign car3_state     = state_bits[2];
  assign arrive_pulse   = arrive_bits;
  assign depart_pulse   = depart_bits;
  assign occupied_count = 2'(state_bits[0]) + 2'(state_bits[1]) + 2'(state_bits[2]);

endmodule

// File: tb/tb_slot_occupancy.sv
module tb_slot_occupancy;

  localparam int D = 4;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] arr;
    logic [2:0] dep;
    logic [1:0] cnt;
  } obs_t;

  logic       clk;
  logic       reset;
  logic [2:0] slot_sensor;
  logic       car1_state, car2_state, car3_state;
  logic [2:0] arrive_pulse, depart_pulse;
  logic [1:0] occupied_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  slot_occupancy #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clk           (clk),
    .reset         (reset),
    .slot_sensor   (slot_sensor),
    .car1_state    (car1_state),
    .car2_state    (car2_state),
    .car3_state    (car3_state),
    .arrive_pulse  (arrive_pulse),
    .depart_pulse  (depart_pulse),
    .occupied_count(occupied_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t       exp_q[$];
  bit   [2:0] raw_q[$] = '{3'b000, 3'b000};
  logic [D-1:0] win [3];
  int         nsamp [3];
  logic [2:0] m_state = 3'b000;

  always @(posedge clk) begin
    obs_t e;
    bit [2:0] s;
    e = '0;
    cyc++;
    if (reset) begin
      raw_q   = '{3'b000, 3'b000};
      m_state = 3'b000;
      for (int b = 0; b < 3; b++) begin
        win[b]   = '0;
        nsamp[b] = 0;
      end
    end else begin
      s = raw_q.pop_front();
      raw_q.push_back(slot_sensor);
      for (int b = 0; b < 3; b++) begin
        win[b] = {win[b][D-2:0], s[b]};
        if (nsamp[b] < D) nsamp[b]++;
        if (nsamp[b] == D && win[b] == {D{~m_state[b]}}) begin
          m_state[b] = ~m_state[b];
          if (m_state[b]) e.arr[b] = 1'b1;
          else            e.dep[b] = 1'b1;
        end
      end
    end
    e.st  = m_state;
    e.cnt = 2'($countones(m_state));
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.st  = {car3_state, car2_state, car1_state};
      a.arr = arrive_pulse;
      a.dep = depart_pulse;
      a.cnt = occupied_count;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d: got st=%b arr=%b dep=%b cnt=%0d, want st=%b arr=%b dep=%b cnt=%0d",
                 cyc, a.st, a.arr, a.dep, a.cnt, e.st, e.arr, e.dep, e.cnt);
      end else begin
        $display("cyc=%0d st=%b arr=%b dep=%b cnt=%0d ok", cyc, a.st, a.arr, a.dep, a.cnt);
      end
    end
  end

  task automatic drive(input logic [2:0] raw, input logic rst, input int n);
    repeat (n) begin
      @(negedge clk);
      slot_sensor = raw;
      reset       = rst;
    end
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] st, input logic [2:0] arr,
                               input logic [2:0] dep, input logic [1:0] cnt);
    n_checks++;
    if ({car3_state, car2_state, car1_state} !== st || arrive_pulse !== arr ||
        depart_pulse !== dep || occupied_count !== cnt) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got st=%b arr=%b dep=%b cnt=%0d, want st=%b arr=%b dep=%b cnt=%0d",
               tag, cyc, {car3_state, car2_state, car1_state}, arrive_pulse, depart_pulse,
               occupied_count, st, arr, dep, cnt);
    end else begin
      $display("%s cyc=%0d st=%b arr=%b dep=%b cnt=%0d ok", tag, cyc,
               {car3_state, car2_state, car1_state}, arrive_pulse, depart_pulse, occupied_count);
    end
  endtask

  initial begin
    logic [2:0] r;
    logic       rr;
    bit         seen_arrive;
    reset       = 1'b1;
    slot_sensor = 3'b111;
    drive(3'b111, 1'b1, 1);
    @(posedge clk);
    #1;
    check_outputs("reset_state", 3'b000, 3'b000, 3'b000, 2'd0);
    seen_arrive = 1'b0;
    for (int w = 0; w < 10; w++) begin
      drive(3'b111, 1'b0, 1);
      #1;
      if (arrive_pulse === 3'b111) seen_arrive = 1'b1;
    end
    n_checks++;
    if (!seen_arrive) begin
      n_fail++;
      $display("FAIL wait_arrive cyc=%0d: arrive_pulse=3'b111 not seen within 10 cycles", cyc);
    end else begin
      $display("wait_arrive cyc=%0d arrive_pulse=111 seen ok", cyc);
    end
    check_outputs("all_occupied", 3'b111, 3'b000, 3'b000, 2'd3);
    drive(3'b000, 1'b0, 10);
    drive(3'b001, 1'b0, 3);
    drive(3'b000, 1'b0, 8);
    drive(3'b001, 1'b0, 4);
    drive(3'b000, 1'b0, 10);
    drive(3'b010, 1'b0, 8);
    for (int i = 0; i < 10; i++) drive((i % 2 == 0) ? 3'b010 : 3'b000, 1'b0, 1);
    drive(3'b010, 1'b0, 8);
    drive(3'b101, 1'b0, 10);
    drive(3'b110, 1'b0, 10);
    drive(3'b000, 1'b0, 10);
    drive(3'b100, 1'b0, 4);
    drive(3'b100, 1'b1, 1);
    drive(3'b100, 1'b0, 10);
    drive(3'b000, 1'b0, 10);
    drive(3'b001, 1'b0, 8);
    drive(3'b011, 1'b0, 8);
    drive(3'b111, 1'b0, 8);
    drive(3'b011, 1'b0, 8);
    drive(3'b001, 1'b0, 8);
    drive(3'b000, 1'b0, 8);
    r = 3'b000;
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      rr = ($urandom_range(0, 149) == 0);
      drive(r, rr, 1);
    end
    drive(3'b000, 1'b0, 12);
    repeat (2) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slot_occupancy.md
Name: slot_occupancy

Overview:
Upstream stage of the parking flag logic. Takes the three raw, noisy, asynchronous bay sensors and synchronizes and debounces each one. It produces the clean per-bay occupancy bits car1_state, car2_state and car3_state that feed the full/empty flag stage. It also emits one-cycle arrival/departure strobes and an occupancy count for the display and gate logic.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive synchronized samples needed to accept a sensor level change (1 ms at 50 MHz); legal range 2..2^20-1; the bench overrides it to 4
CNT_W, 20, width of each per-bay debounce counter; must hold DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
slot_sensor  input  3  raw bay sensors, 1 = car detected; bit0 = bay1, bit1 = bay2, bit2 = bay3; asynchronous to clk
car1_state  output  1  debounced occupancy of bay 1, registered
car2_state  output  1  debounced occupancy of bay 2, registered
car3_state  output  1  debounced occupancy of bay 3, registered
arrive_pulse  output  3  one-cycle strobe when a bay becomes occupied, registered
depart_pulse  output  3  one-cycle strobe when a bay becomes free, registered
occupied_count  output  2  number of occupied bays, 0..3

Behaviour:
- One clock (clk). Reset is synchronous, active-high, and overrides everything.
- Reset values: car1_state/car2_state/car3_state = 0, arrive_pulse = 0, depart_pulse = 0, occupied_count = 0. All sync flops = 0, all counters = 0, all bay FSMs = EMPTY.
- Synchronizer: a 2-flop chain per bit gives sens_s[i]. No other logic reads slot_sensor directly.
- Per-bay FSM, three independent identical instances: EMPTY, ARRIVING, OCCUPIED, DEPARTING.
  - EMPTY: if sens_s = 1, go to ARRIVING with cnt <= 1. Otherwise stay.
  - ARRIVING, sens_s = 0: return to EMPTY, cnt <= 0 (glitch rejected, no strobe).
  - ARRIVING, sens_s = 1 and cnt == DEBOUNCE_CYCLES-1: go to OCCUPIED, state bit <= 1, arrive_pulse[i] <= 1, cnt <= 0.
  - ARRIVING, sens_s = 1 otherwise: cnt <= cnt+1.
  - OCCUPIED and DEPARTING mirror the above with sens_s inverted. The completing edge sets the state bit to 0 and depart_pulse[i] to 1.
- Debounce threshold: a raw level held for exactly DEBOUNCE_CYCLES clocks is accepted. A level held for DEBOUNCE_CYCLES-1 clocks is rejected.
- Latency: if raw rises before edge 1 and is held, the state bit is 1 after edge DEBOUNCE_CYCLES+2. Falling latency is identical.
- Strobes: high for exactly one cycle, on the same cycle the state bit changes. Never asserted otherwise.
- occupied_count is the combinational sum of the three registered state bits. It is always consistent with them in the same cycle and has no extra latency.
- Simultaneous events on different bays are fully independent. Multiple strobe bits may be high in the same cycle, and the count changes by the net amount.
- Reset mid-debounce discards the partial count with no strobe.
- After reset with a sensor held high, the first clean edge (reset low) counts as edge 1. The bay rises DEBOUNCE_CYCLES+2 edges later and arrive_pulse fires.
- A sensor held indefinitely produces no repeated strobes, and the counter does not wrap.

Test Plan:
1. DEBOUNCE_CYCLES=4. Assert reset 2 cycles with slot_sensor=3'b111 -> all outputs 0 throughout reset. After release, car1..3_state rise together after edge 6, arrive_pulse=3'b111 for 1 cycle, occupied_count goes 0->3.
2. Bay1 raw high for 3 clocks, then low -> car1_state stays 0, no arrive_pulse[0]. Repeat with 4 clocks -> car1_state=1 after edge 6, arrive_pulse[0] pulses once.
3. Bay2 occupied, then raw chatter 1-0-1-0 each cycle for 10 cycles, then steady 1 -> car2_state stays 1, no depart_pulse[1].
4. Bays 1 and 3 occupied. Raw bay1 falls and raw bay2 rises on the same cycle -> on the same cycle depart_pulse=3'b001, arrive_pulse=3'b010, occupied_count stays 2.
5. Bay3 raw high; reset asserted at cnt=2 -> no strobe, car3_state=0. After release, a full DEBOUNCE_CYCLES+2 edges pass before car3_state=1.
6. Fill bays 1->2->3 sequentially, then empty them 3->2->1 -> occupied_count steps 1,2,3,2,1,0, with exactly one strobe per transition.
